// File: rtl/trigger_seq_if.sv
// Capture stream bundle around the trigger sequencer: raw input stream (sti_*)
// and the registered output stream with its trigger flag (sto_*).
interface trigger_seq_if #(
  parameter int SDW = 32
);

  logic [SDW-1:0] sti_tdata;
  logic           sti_tvalid;
  logic           sti_tready;
  logic [SDW-1:0] sto_tdata;
  logic           sto_tvalid;
  logic           sto_trigger;
  logic           sto_tready;

  // Sequencer side: consumes sti, produces sto.
  modport slave (
    input  sti_tdata,
    input  sti_tvalid,
    output sti_tready,
    output sto_tdata,
    output sto_tvalid,
    output sto_trigger,
    input  sto_tready
  );

  // Environment side: produces sti, consumes sto.
  modport master (
    output sti_tdata,
    output sti_tvalid,
    input  sti_tready,
    input  sto_tdata,
    input  sto_tvalid,
    input  sto_trigger,
    output sto_tready
  );

endinterface

// File: rtl/trigger_seq.sv
// Multi-stage sequential trigger. Forwards the capture stream through a
// one-deep register slice and tags the transfer that completes the final
// active stage with sto_trigger.
module trigger_seq #(
  parameter int SDW = 32,
  parameter int TSN = 4,
  parameter int TCW = 16,
  parameter int TNW = $clog2(TSN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctl_arm,
  input  logic               ctl_disarm,
  input  logic [TSN*SDW-1:0] cfg_msk,
  input  logic [TSN*SDW-1:0] cfg_val,
  input  logic [TSN*TCW-1:0] cfg_cnt,
  input  logic [TNW-1:0]     cfg_nst,
  output logic               sts_arm,
  output logic               sts_fire,
  output logic [TNW-1:0]     sts_stage,
  trigger_seq_if.slave       str
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_FIRED = 2'd2;

  logic [1:0]     state;
  logic [TNW-1:0] stage;
  logic [TCW-1:0] cnt;
  logic           fire_flag;

  logic [SDW-1:0] tdata_q;
  logic           tvalid_q;
  logic           trig_q;

  logic [TSN-1:0] stage_match;
  logic [TCW-1:0] stage_cnt [TSN];
  logic           cur_match;
  logic [TCW-1:0] cur_cnt;
  logic           in_xfer;
  logic           eval;
  logic           last_stage;
  logic           nst_zero;
  logic           cnt_done;
  logic           fire_now;

  // Per-stage masked compare of the incoming word and per-stage count unpack.
  always_comb begin
    for (int unsigned k = 0; k < TSN; k++) begin
      stage_match[k] = ((str.sti_tdata ^ cfg_val[k*SDW +: SDW]) & cfg_msk[k*SDW +: SDW]) == '0;
      stage_cnt[k]   = cfg_cnt[k*TCW +: TCW];
    end
  end

  // Pick the compare result and required count of the current stage.
  always_comb begin
    cur_match = 1'b0;
    cur_cnt   = '0;
    for (int unsigned k = 0; k < TSN; k++) begin
      if (stage == TNW'(k)) begin
        cur_match = stage_match[k];
        cur_cnt   = stage_cnt[k];
      end
    end
  end

  // Handshake and fire decision for the transfer in this cycle.
  // A transfer coinciding with an arm or disarm pulse is never evaluated.
  always_comb begin
    str.sti_tready = ~tvalid_q | str.sto_tready;
    in_xfer        = str.sti_tvalid & str.sti_tready;
    eval           = in_xfer & (state == S_ARMED) & ~ctl_arm & ~ctl_disarm;
    nst_zero       = (cfg_nst == '0);
    last_stage     = (stage == (cfg_nst - TNW'(1)));
    cnt_done       = (cnt == cur_cnt);
    fire_now       = eval & (nst_zero | (cur_match & cnt_done & last_stage));
  end

  // Sequencer state: disarm beats arm, arm beats stream evaluation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      stage     <= '0;
      cnt       <= '0;
      fire_flag <= 1'b0;
    end else if (ctl_disarm) begin
      state <= S_IDLE;
      stage <= '0;
      cnt   <= '0;
    end else if (ctl_arm) begin
      state     <= S_ARMED;
      stage     <= '0;
      cnt       <= '0;
      fire_flag <= 1'b0;
    end else if (eval) begin
      if (fire_now) begin
        state     <= S_FIRED;
        fire_flag <= 1'b1;
      end else if (cur_match) begin
        if (cnt_done) begin
          stage <= stage + TNW'(1);
          cnt   <= '0;
        end else begin
          cnt <= cnt + TCW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Output register slice: load on input transfer, empty on drain-only cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      trig_q   <= 1'b0;
    end else if (in_xfer) begin
      tdata_q  <= str.sti_tdata;
      tvalid_q <= 1'b1;
      trig_q   <= fire_now;
    end else if (str.sto_tready) begin
      tvalid_q <= 1'b0;
      trig_q   <= 1'b0;
    end
  end

  // Drive stream outputs and status from the registered state.
  always_comb begin
    str.sto_tdata   = tdata_q;
    str.sto_tvalid  = tvalid_q;
    str.sto_trigger = trig_q;
    sts_arm         = (state == S_ARMED);
    sts_fire        = fire_flag;
    sts_stage       = stage;
  end

endmodule

// File: tb/tb_trigger_seq.sv
// Bench for trigger_seq: vector table, directed corner sequences, and random
// traffic checked every cycle against a cycle-level behavioural model.
module tb_trigger_seq;

  localparam int SDW = 32;
  localparam int TSN = 4;
  localparam int TCW = 4;
  localparam int TNW = $clog2(TSN + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ctl_arm = 1'b0;
  logic ctl_disarm = 1'b0;
  logic [TSN*SDW-1:0] cfg_msk;
  logic [TSN*SDW-1:0] cfg_val;
  logic [TSN*TCW-1:0] cfg_cnt;
  logic [TNW-1:0]     cfg_nst = '0;
  logic               sts_arm;
  logic               sts_fire;
  logic [TNW-1:0]     sts_stage;

  logic [SDW-1:0] msk_a [TSN];
  logic [SDW-1:0] val_a [TSN];
  logic [TCW-1:0] cnt_a [TSN];

  always #5 clk = ~clk;

  trigger_seq_if #(.SDW(SDW)) bus ();

  trigger_seq #(.SDW(SDW), .TSN(TSN), .TCW(TCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctl_arm   (ctl_arm),
    .ctl_disarm(ctl_disarm),
    .cfg_msk   (cfg_msk),
    .cfg_val   (cfg_val),
    .cfg_cnt   (cfg_cnt),
    .cfg_nst   (cfg_nst),
    .sts_arm   (sts_arm),
    .sts_fire  (sts_fire),
    .sts_stage (sts_stage),
    .str       (bus)
  );

  always_comb begin
    cfg_msk = '0;
    cfg_val = '0;
    cfg_cnt = '0;
    for (int k = 0; k < TSN; k++) begin
      cfg_msk[k*SDW +: SDW] = msk_a[k];
      cfg_val[k*SDW +: SDW] = val_a[k];
      cfg_cnt[k*TCW +: TCW] = cnt_a[k];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: armed?, fired?, which stage, length of the current run of matches.
  logic           m_valid = 1'b0, m_trig = 1'b0, m_armed = 1'b0, m_fired = 1'b0;
  logic [SDW-1:0] m_data = '0;
  int             m_stage = 0, m_run = 0;
  logic           n_valid, n_trig, n_armed, n_fired;
  logic [SDW-1:0] n_data;
  int             n_stage, n_run;
  logic           in_x, fire_x;
  int             nst;

  always_comb begin
    n_valid = m_valid; n_trig = m_trig; n_armed = m_armed; n_fired = m_fired;
    n_data = m_data; n_stage = m_stage; n_run = m_run;
    nst    = int'(cfg_nst);
    in_x   = bus.sti_tvalid && (!m_valid || bus.sto_tready);
    fire_x = 1'b0;
    if (in_x && m_armed && !ctl_arm && !ctl_disarm) begin
      if (nst == 0) begin
        fire_x = 1'b1;
      end else if (((bus.sti_tdata ^ val_a[m_stage]) & msk_a[m_stage]) == '0) begin
        if (m_run + 1 == int'(cnt_a[m_stage]) + 1) begin
          if (m_stage == nst - 1) fire_x = 1'b1;
          else begin n_stage = m_stage + 1; n_run = 0; end
        end else begin
          n_run = m_run + 1;
        end
      end else begin
        n_run = 0;
      end
      if (fire_x) begin n_armed = 1'b0; n_fired = 1'b1; end
    end
    if (ctl_disarm) begin
      n_armed = 1'b0; n_stage = 0; n_run = 0;
    end else if (ctl_arm) begin
      n_armed = 1'b1; n_fired = 1'b0; n_stage = 0; n_run = 0;
    end
    if (in_x) begin
      n_valid = 1'b1; n_data = bus.sti_tdata; n_trig = fire_x;
    end else if (bus.sto_tready) begin
      n_valid = 1'b0; n_trig = 1'b0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_trig <= 1'b0; m_armed <= 1'b0; m_fired <= 1'b0;
      m_data <= '0; m_stage <= 0; m_run <= 0;
    end else begin
      m_valid <= n_valid; m_trig <= n_trig; m_armed <= n_armed; m_fired <= n_fired;
      m_data <= n_data; m_stage <= n_stage; m_run <= n_run;
    end
  end

  // ---------------- per-cycle monitor ----------------
  int             trig_cnt = 0;
  logic [SDW-1:0] last_trig = '0;
  logic           stalled_p = 1'b0;
  logic [SDW-1:0] stall_d = '0;
  logic           stall_t = 1'b0;

  always @(negedge clk) begin
    chk("mdl_tvalid", bus.sto_tvalid, m_valid);
    chk("mdl_tready", bus.sti_tready, !m_valid || bus.sto_tready);
    if (m_valid) begin
      chk("mdl_tdata", bus.sto_tdata, m_data);
      chk("mdl_trigger", bus.sto_trigger, m_trig);
    end
    chk("mdl_sts_arm", sts_arm, m_armed);
    chk("mdl_sts_fire", sts_fire, m_fired);
    chk("mdl_sts_stage", 64'(sts_stage), 64'(m_stage));
    if (stalled_p && rst) begin
      chk("stall_tdata", bus.sto_tdata, stall_d);
      chk("stall_trigger", bus.sto_trigger, stall_t);
    end
    if (bus.sto_tvalid && bus.sto_tready && bus.sto_trigger) begin
      trig_cnt  <= trig_cnt + 1;
      last_trig <= bus.sto_tdata;
    end
    stalled_p <= rst && bus.sto_tvalid && !bus.sto_tready;
    stall_d   <= bus.sto_tdata;
    stall_t   <= bus.sto_trigger;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [SDW-1:0] d);
    bus.sti_tvalid = 1'b1;
    bus.sti_tdata  = d;
    step();
  endtask

  task automatic pulse_arm();
    bus.sti_tvalid = 1'b0;
    ctl_arm = 1'b1;
    step();
    ctl_arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    bus.sti_tvalid = 1'b0;
    ctl_disarm = 1'b1;
    step();
    ctl_disarm = 1'b0;
  endtask

  task automatic cfg_clear();
    cfg_nst = '0;
    for (int k = 0; k < TSN; k++) begin
      msk_a[k] = '0; val_a[k] = '0; cnt_a[k] = '0;
    end
  endtask

  typedef struct {
    logic       arm;
    logic       vld;
    logic [7:0] din;
    logic       exp_v;
    logic       exp_t;
  } vec_t;

  vec_t tbl [33];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc0;
    int nxt;
    int cyc;
    logic acc;

    bus.sti_tvalid = 1'b0;
    bus.sti_tdata  = '0;
    bus.sto_tready = 1'b1;
    cfg_clear();

    // reset state
    repeat (2) step();
    chk("rst_tvalid", bus.sto_tvalid, 0);
    chk("rst_tdata", bus.sto_tdata, 0);
    chk("rst_trigger", bus.sto_trigger, 0);
    chk("rst_sts_arm", sts_arm, 0);
    chk("rst_sts_fire", sts_fire, 0);
    chk("rst_sts_stage", 64'(sts_stage), 0);
    rst = 1'b1;
    step();

    // table: bypass 0..15 while idle, then arm and single-stage trigger on 5
    cfg_nst = TNW'(1); msk_a[0] = 32'hFF; val_a[0] = 32'h05; cnt_a[0] = '0;
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 1'b1, 8'(i), 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) tbl[17+i] = '{1'b0, 1'b1, 8'(i), 1'b1, (i == 5)};
    tc0 = trig_cnt;
    for (int i = 0; i < 33; i++) begin
      ctl_arm        = tbl[i].arm;
      bus.sti_tvalid = tbl[i].vld;
      bus.sti_tdata  = 32'(tbl[i].din);
      step();
      ctl_arm = 1'b0;
      chk("tbl_tvalid", bus.sto_tvalid, tbl[i].exp_v);
      if (tbl[i].exp_v) begin
        chk("tbl_tdata", bus.sto_tdata, 64'(tbl[i].din));
        chk("tbl_trigger", bus.sto_trigger, tbl[i].exp_t);
      end
    end
    bus.sti_tvalid = 1'b0;
    step();
    chk("single_fire", sts_fire, 1);
    chk("single_arm_cleared", sts_arm, 0);
    chk("single_trig_count", 64'(trig_cnt - tc0), 1);

    // two-stage sequence 3,3,4,7 -> trigger on 7
    pulse_disarm();
    cfg_clear();
    cfg_nst = TNW'(2);
    msk_a[0] = 32'hFF; val_a[0] = 32'h03; cnt_a[0] = TCW'(1);
    msk_a[1] = 32'hFF; val_a[1] = 32'h07; cnt_a[1] = '0;
    pulse_arm();
    tc0 = trig_cnt;
    send(32'd3); chk("seq_stage_after_3", 64'(sts_stage), 0);
    send(32'd3); chk("seq_stage_after_33", 64'(sts_stage), 1);
    send(32'd4); chk("seq_trig_on_4", bus.sto_trigger, 0);
    send(32'd7);
    chk("seq_data_7", bus.sto_tdata, 7);
    chk("seq_trig_on_7", bus.sto_trigger, 1);
    bus.sti_tvalid = 1'b0;
    step();
    chk("seq_trig_count", 64'(trig_cnt - tc0), 1);
    chk("seq_fire", sts_fire, 1);

    // 3,4,3,7 never completes stage 0
    pulse_arm();
    tc0 = trig_cnt;
    send(32'd3); send(32'd4); send(32'd3); send(32'd7);
    chk("seq2_trig_on_7", bus.sto_trigger, 0);
    bus.sti_tvalid = 1'b0;
    step();
    chk("seq2_stage", 64'(sts_stage), 0);
    chk("seq2_arm", sts_arm, 1);
    chk("seq2_trig_count", 64'(trig_cnt - tc0), 0);

    // backpressure and gaps, trigger on 5
    pulse_disarm();
    cfg_clear();
    cfg_nst = TNW'(1); msk_a[0] = 32'hFF; val_a[0] = 32'h05;
    pulse_arm();
    tc0 = trig_cnt;
    nxt = 0;
    cyc = 0;
    while (nxt < 20 && cyc < 2000) begin
      bus.sti_tvalid = ($urandom_range(3) != 0);
      bus.sti_tdata  = 32'(nxt);
      bus.sto_tready = 1'($urandom_range(1));
      #1;
      acc = bus.sti_tvalid && bus.sti_tready;
      step();
      if (acc) nxt++;
      cyc++;
    end
    bus.sti_tvalid = 1'b0;
    bus.sto_tready = 1'b1;
    repeat (3) step();
    chk("bp_all_sent", 64'(nxt), 20);
    chk("bp_trig_count", 64'(trig_cnt - tc0), 1);
    chk("bp_trig_data", last_trig, 5);

    // arm and disarm together: disarm wins
    pulse_disarm();
    ctl_arm = 1'b1; ctl_disarm = 1'b1;
    step();
    ctl_arm = 1'b0; ctl_disarm = 1'b0;
    chk("arm_disarm_same", sts_arm, 0);

    // no active stages: transfer with the arm pulse is skipped, next one fires
    cfg_clear();
    ctl_arm = 1'b1;
    bus.sti_tvalid = 1'b1; bus.sti_tdata = 32'hAA;
    step();
    ctl_arm = 1'b0;
    chk("nst0_arm_cycle_trig", bus.sto_trigger, 0);
    send(32'hBB);
    chk("nst0_first_data", bus.sto_tdata, 32'hBB);
    chk("nst0_first_trig", bus.sto_trigger, 1);
    send(32'hCC);
    chk("nst0_second_trig", bus.sto_trigger, 0);
    chk("nst0_fire", sts_fire, 1);

    // re-arm after fire gives a second trigger
    pulse_arm();
    chk("rearm_fire_cleared", sts_fire, 0);
    chk("rearm_arm", sts_arm, 1);
    send(32'hDD);
    chk("rearm_trig", bus.sto_trigger, 1);

    // counter at its maximum needs 2^TCW matches; zero mask always matches
    pulse_disarm();
    cfg_clear();
    cfg_nst = TNW'(1); cnt_a[0] = '1;
    pulse_arm();
    for (int i = 0; i < (1 << TCW) - 1; i++) begin
      send($urandom);
      chk("cntmax_early_trig", bus.sto_trigger, 0);
    end
    send($urandom);
    chk("cntmax_final_trig", bus.sto_trigger, 1);

    // random traffic and configurations against the model
    bus.sti_tvalid = 1'b0;
    pulse_disarm();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(39) == 0) begin
        pulse_disarm();
        cfg_nst = TNW'($urandom_range(TSN));
        for (int k = 0; k < TSN; k++) begin
          msk_a[k] = 32'($urandom_range(3));
          val_a[k] = 32'($urandom_range(3));
          cnt_a[k] = TCW'($urandom_range(2));
        end
      end
      ctl_arm        = ($urandom_range(14) == 0);
      bus.sti_tvalid = ($urandom_range(3) != 0);
      bus.sti_tdata  = {$urandom_range(255), 30'h0} | 32'($urandom_range(3));
      bus.sto_tready = ($urandom_range(3) != 0);
      step();
      ctl_arm = 1'b0;
    end
    bus.sti_tvalid = 1'b0;
    bus.sto_tready = 1'b1;
    step();

    // reset mid-stream while armed at stage 1 with a word held in the slice
    pulse_disarm();
    cfg_clear();
    cfg_nst = TNW'(2);
    msk_a[0] = 32'hFF; val_a[0] = 32'h03;
    msk_a[1] = 32'hFF; val_a[1] = 32'h09;
    pulse_arm();
    send(32'd3);
    chk("rst_pre_stage", 64'(sts_stage), 1);
    bus.sti_tvalid = 1'b0;
    bus.sto_tready = 1'b0;
    step();
    chk("rst_pre_tvalid", bus.sto_tvalid, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_tvalid", bus.sto_tvalid, 0);
    chk("rst_mid_tdata", bus.sto_tdata, 0);
    chk("rst_mid_trigger", bus.sto_trigger, 0);
    chk("rst_mid_sts_arm", sts_arm, 0);
    chk("rst_mid_sts_stage", 64'(sts_stage), 0);
    step();
    rst = 1'b1;
    bus.sto_tready = 1'b1;
    tc0 = trig_cnt;
    send(32'd9);
    chk("post_rst_data", bus.sto_tdata, 9);
    chk("post_rst_trig", bus.sto_trigger, 0);
    send(32'd3);
    bus.sti_tvalid = 1'b0;
    step();
    chk("post_rst_trig_count", 64'(trig_cnt - tc0), 0);
    chk("post_rst_arm", sts_arm, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trigger_seq.md
Name: trigger_seq

Overview:
- Multi-stage sequential trigger. Sits directly upstream of sampler: consumes the raw capture stream and forwards it unchanged with a registered one-cycle slice.
- Drives the trigger flag that sampler receives on sti_trigger.
- Each stage matches a masked value for a programmable number of consecutive transfers, then advances to the next stage.
- Completing the final active stage flags exactly one transfer.

Parameters:
SDW, 32, sample data width
TSN, 4, number of trigger stages implemented
TCW, 16, per-stage match counter width
TNW, $clog2(TSN+1), width of active stage count

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset; asserted when 0
ctl_arm  input  1  single-cycle pulse; arm the trigger, restart at stage 0
ctl_disarm  input  1  single-cycle pulse; return to idle
cfg_msk  input  TSN*SDW  per-stage compare mask; stage k occupies bits [k*SDW +: SDW]
cfg_val  input  TSN*SDW  per-stage compare value; same packing as cfg_msk
cfg_cnt  input  TSN*TCW  per-stage extra match count; stage k needs cfg_cnt[k]+1 consecutive matches
cfg_nst  input  TNW  number of active stages, 0..TSN
sts_arm  output  1  armed and not yet fired
sts_fire  output  1  trigger fired since last arm
sts_stage  output  TNW  current stage index
sti_tdata  input  SDW  input stream data
sti_tvalid  input  1  input stream valid
sti_tready  output  1  input stream ready
sto_tdata  output  SDW  output stream data
sto_tvalid  output  1  output stream valid
sto_trigger  output  1  trigger flag attached to the output transfer
sto_tready  input  1  output stream ready

Behaviour:
- Reset (rst=0, async): sto_tvalid=0, sto_tdata=0, sto_trigger=0, sts_arm=0, sts_fire=0, sts_stage=0; state IDLE; match counter=0.
- Stream:
  - sti_tready = ~sto_tvalid | sto_tready (combinational).
  - An input transfer is sti_tvalid & sti_tready. It loads sto_tdata and sets sto_tvalid on the next edge.
  - sto_tvalid clears after an output transfer that has no concurrent input transfer.
  - Latency is 1 cycle. Full throughput: one transfer per cycle with sto_tready held high.
  - Data passes through in every state. No drop, no duplication.
  - sto_tdata and sto_trigger stay stable while sto_tvalid=1 and sto_tready=0.
- Match, stage k: ((sti_tdata ^ cfg_val[k]) & cfg_msk[k]) == 0. A mask of all zeros always matches.
- Matching is evaluated only on input transfers. Idle cycles neither advance nor reset the counter.
- State machine:
  - IDLE: sto_trigger=0 on all transfers. ctl_arm -> ARMED, stage=0, cnt=0.
  - ARMED, transfer matches, cnt==cfg_cnt[stage]:
    - if stage==cfg_nst-1, go to FIRED and set sto_trigger=1 on this same transfer;
    - otherwise stage++ and cnt=0.
  - ARMED, transfer matches, cnt<cfg_cnt[stage]: cnt++.
  - ARMED, transfer does not match: cnt=0, stage unchanged.
  - ARMED with cfg_nst==0: the first input transfer after arming fires.
  - FIRED: sts_fire=1, sto_trigger=0 on all later transfers. ctl_arm re-arms and clears sts_fire.
- sto_trigger is 1 on exactly one output transfer per arm.
- Arm and disarm timing:
  - Arm takes effect on the edge after the ctl_arm pulse. A transfer in the same cycle as ctl_arm is not evaluated.
  - ctl_disarm -> IDLE from any state; clears sts_arm and sts_stage. sts_fire is left unchanged.
  - ctl_arm and ctl_disarm in the same cycle: disarm wins.
  - ctl_arm while ARMED restarts at stage 0 with cnt=0.
- Status:
  - sts_arm=1 only in ARMED.
  - sts_stage shows the current stage in ARMED and holds its last value in FIRED.
- Counter: TCW bits. cfg_cnt=2^TCW-1 requires 2^TCW consecutive matches, and cnt never wraps.
- cfg_* must be static while ARMED. Changing them while ARMED gives undefined results, but stream data stays correct.
- Reset mid-operation: all state and the output slice clear immediately. An in-flight output word is discarded.

Test Plan:
- Bypass: idle, stream 0..15 with sto_tready=1 -> output 0..15 in order, 1-cycle latency, sto_trigger=0 throughout.
- Single stage: cfg_nst=1, msk0=0xFF, val0=0x05, cnt0=0; arm, stream 0..15 -> sto_trigger=1 only on data 5, sts_fire=1 afterwards.
- Sequence: cfg_nst=2, stage0 val 0x03 cnt 1, stage1 val 0x07 cnt 0, msk 0xFF; stream 3,3,4,7 -> trigger on the 7. Stream 3,4,3,7 instead -> no trigger and sts_stage stays 0.
- Backpressure: single-stage trigger on 5, random sto_tready and sti_tvalid gaps -> data order kept, trigger on 5 exactly once, output held stable while stalled.
- Control corners:
  - arm and disarm in the same cycle -> sts_arm=0;
  - cfg_nst=0 -> trigger on the first transfer after arm;
  - re-arm after fire -> a second trigger is produced.
- Reset: assert rst=0 mid-stream while ARMED at stage 1 with sto_tvalid=1 -> all outputs return to 0 immediately; after release, traffic resumes as bypass.
